// File: rtl/trans_framer.sv
// Byte-stream framer: packs 16 bytes (MSB first) into 128-bit words, buffers them
// in a small FIFO and presents them on a valid/ack output register.
module trans_framer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   byte_i,
  input  logic         byte_valid_i,
  output logic         byte_ready_o,
  output logic [127:0] data_o,
  output logic         valid_o,
  input  logic         ack_i,
  output logic [15:0]  frame_cnt_o,
  output logic [15:0]  drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PUSH} state_e;

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [TW-1:0]  idle_q, idle_d;
  logic [127:0]   shift_q, shift_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [127:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic [127:0]   mem_q [DEPTH];

  logic accept, full, empty, pop, wr_en;

  // Handshakes: a byte moves when byte_valid_i && byte_ready_o at a rising edge;
  // a word is consumed when valid_o && ack_i at a rising edge, ack_i otherwise ignored.
  assign byte_ready_o = (state_q != S_PUSH);
  assign accept       = byte_valid_i && byte_ready_o;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign pop          = (!valid_q || ack_i) && !empty;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    idle_d      = idle_q;
    shift_d     = shift_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    wr_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d[127:120] = byte_i;
          idx_d   = 4'd1;
          idle_d  = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          shift_d[{4'd15 - idx_q, 3'b000} +: 8] = byte_i;
          idx_d  = idx_q + 4'd1;
          idle_d = '0;
          if (idx_q == 4'd15) state_d = S_PUSH;
        end else if (TIMEOUT != 0) begin
          // The idle count reaching TIMEOUT-1 here makes this the TIMEOUT-th quiet cycle.
          if (idle_q == TW'(TIMEOUT - 1)) begin
            idle_d  = '0;
            state_d = S_IDLE;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            idle_d = idle_q + TW'(1);
          end
        end
      end
      S_PUSH: begin
        if (!full) begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
          if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
    data_d  = data_q;
    valid_d = valid_q;
    if (pop) begin
      data_d  = mem_q[rd_ptr_q];
      valid_d = 1'b1;
    end else if (ack_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      idle_q      <= '0;
      shift_q     <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      idle_q      <= idle_d;
      shift_q     <= shift_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_cnt_o = frame_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_trans_framer.sv
// Self-checking bench for trans_framer (DEPTH=4, TIMEOUT=8): table-driven frames
// plus hand-written sequences for backpressure, timeout, reset and ack corners.
module tb_trans_framer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   byte_i = '0;
  logic         byte_valid_i = 1'b0;
  logic         byte_ready_o;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ack_i = 1'b0;
  logic [15:0]  frame_cnt_o;
  logic [15:0]  drop_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [127:0] exp_q[$];

  localparam int LIM = 200;

  trans_framer #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .data_o(data_o), .valid_o(valid_o), .ack_i(ack_i),
    .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    byte_valid_i = 1'b0;
    ack_i = 1'b0;
    step(1);
    rst_n = 1'b1;
    exp_q.delete();
    check("rst_valid", 128'(valid_o), 128'(0));
    check("rst_data", data_o, 128'(0));
    check("rst_frame_cnt", 128'(frame_cnt_o), 128'(0));
    check("rst_drop_cnt", 128'(drop_cnt_o), 128'(0));
    check("rst_ready", 128'(byte_ready_o), 128'(1));
  endtask

  // driver tasks: called #1 after a rising edge, return #1 after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && n < LIM) begin
      step(1);
      n++;
    end
    if (n >= LIM) check("byte_ready_timeout", 128'(0), 128'(1));
    step(1);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] start, input logic [7:0] inc, input bit push);
    logic [127:0] w = '0;
    logic [7:0] b = start;
    for (int i = 0; i < 16; i++) begin
      send_byte(b);
      w = {w[119:0], b};
      b = b + inc;
    end
    if (push) exp_q.push_back(w);
  endtask

  // scoreboard: wait for a word, compare it with the queue head, then ack it
  task automatic take_word(input string name, input int ack_dly);
    int n = 0;
    logic [127:0] e;
    while (!valid_o && n < LIM) begin
      step(1);
      n++;
    end
    if (n >= LIM) begin
      check({name, "_valid_timeout"}, 128'(valid_o), 128'(1));
    end else begin
      step(ack_dly);
      if (exp_q.size() == 0) begin
        check({name, "_unexpected_word"}, data_o, 128'(0));
        tests_failed += (data_o == 128'(0)) ? 1 : 0;
      end else begin
        e = exp_q.pop_front();
        check(name, data_o, e);
      end
      ack_i = 1'b1;
      step(1);
      ack_i = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0]   start;
    logic [7:0]   inc;
    int           ack_dly;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{8'h00, 8'h01, 1, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{8'hA0, 8'h01, 3, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf};
    vecs[2] = '{8'hFF, 8'h00, 0, 128'hffffffffffffffffffffffffffffffff};
    vecs[3] = '{8'h10, 8'h10, 5, 128'h102030405060708090a0b0c0d0e0f000};

    step(2);
    do_reset();

    // single frame with latency check
    send_frame(8'h00, 8'h01, 1'b1);
    check("lat_e0", 128'(valid_o), 128'(0));
    step(1);
    check("lat_e1", 128'(valid_o), 128'(0));
    step(1);
    check("lat_e2", 128'(valid_o), 128'(1));
    check("single_data", data_o, 128'h000102030405060708090a0b0c0d0e0f);
    take_word("single_word", 1);
    check("single_valid_clear", 128'(valid_o), 128'(0));
    check("single_frame_cnt", 128'(frame_cnt_o), 128'(1));

    // table-driven frames
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].start, vecs[i].inc, 1'b0);
      exp_q.push_back(vecs[i].exp);
      take_word($sformatf("vec%0d_word", i), vecs[i].ack_dly);
      check($sformatf("vec%0d_frame_cnt", i), 128'(frame_cnt_o), 128'(i + 1));
    end

    // backpressure: 6 frames with no ack
    do_reset();
    for (int f = 0; f < 6; f++) send_frame(8'(f * 32), 8'h01, 1'b1);
    check("bp_stall_ready", 128'(byte_ready_o), 128'(0));
    step(3);
    check("bp_stall_hold", 128'(byte_ready_o), 128'(0));
    check("bp_frame_cnt5", 128'(frame_cnt_o), 128'(5));
    check("bp_valid", 128'(valid_o), 128'(1));
    take_word("bp_word0", 0);
    check("bp_ready_after_ack", 128'(byte_ready_o), 128'(0));
    step(1);
    check("bp_ready_back", 128'(byte_ready_o), 128'(1));
    check("bp_frame_cnt6", 128'(frame_cnt_o), 128'(6));
    for (int f = 1; f < 6; f++) take_word($sformatf("bp_word%0d", f), f % 3);
    step(3);
    check("bp_drained", 128'(valid_o), 128'(0));

    // timeout: 9-cycle gap drops the partial frame
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i));
    step(9);
    check("to_drop_cnt", 128'(drop_cnt_o), 128'(1));
    send_frame(8'hA0, 8'h01, 1'b0);
    exp_q.push_back(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
    take_word("to_word", 1);
    check("to_frame_cnt", 128'(frame_cnt_o), 128'(1));
    check("to_drop_cnt_after", 128'(drop_cnt_o), 128'(1));

    // gap of 7 stays below the limit
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h31 + i));
    step(7);
    for (int i = 5; i < 16; i++) send_byte(8'(8'h31 + i));
    exp_q.push_back(128'h3132333435363738393a3b3c3d3e3f40);
    take_word("gap_word", 2);
    check("gap_drop_cnt", 128'(drop_cnt_o), 128'(0));
    check("gap_frame_cnt", 128'(frame_cnt_o), 128'(1));

    // reset mid-frame with a word pending
    do_reset();
    send_frame(8'h70, 8'h01, 1'b1);
    step(2);
    check("mid_pending_valid", 128'(valid_o), 128'(1));
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
    do_reset();
    send_frame(8'h50, 8'h03, 1'b1);
    take_word("mid_clean_word", $urandom_range(0, 4));
    check("mid_frame_cnt", 128'(frame_cnt_o), 128'(1));

    // ack while idle, then ack on the same edge as a FIFO write
    do_reset();
    ack_i = 1'b1;
    step(1);
    ack_i = 1'b0;
    check("idle_ack_valid", 128'(valid_o), 128'(0));
    check("idle_ack_frame_cnt", 128'(frame_cnt_o), 128'(0));
    send_frame(8'hC0, 8'h01, 1'b1);
    send_frame(8'hD0, 8'h01, 1'b1);
    send_frame(8'hE0, 8'h02, 1'b1);
    check("coll_in_push", 128'(byte_ready_o), 128'(0));
    check("coll_head", data_o, exp_q.pop_front());
    ack_i = 1'b1;
    step(1);
    ack_i = 1'b0;
    check("coll_frame_cnt", 128'(frame_cnt_o), 128'(3));
    take_word("coll_word1", 1);
    take_word("coll_word2", 0);
    step(4);
    check("coll_no_extra", 128'(valid_o), 128'(0));
    check("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
